theatre_console: RTL and testbench
==================================

// Module: theatre_console
// PURPOSE
//  Front-of-house console conditioner; sits directly upstream of the theatre lighting/video controller.
//  Synchronises and debounces raw operator buttons and stage-tracker sensors.
//  Drives a registered enable, a one-hot (or all-zero) mode set House/Music/Speaker/Play, and filtered active-low TL/TC/TR.
//  Inserts an all-off blanking gap between mode changes so downstream lights never overlap.
// PARAMETERS
//  DB_CYCLES     4  consecutive differing sync samples before a button's debounced level flips (>=1)
//  BLANK_CYCLES  2  all-mode-off cycles inserted when leaving an active mode for another (>=1)
//  TRK_STABLE    3  consecutive identical valid tracker samples before TL/TC/TR update (>=1)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  btn_en       in   1  raw master-enable key switch, level, async
//  btn_off      in   1  raw "all modes off" button, async, bouncy
//  btn_house    in   1  raw house-mode button
//  btn_music    in   1  raw music-mode button
//  btn_speaker  in   1  raw speaker-mode button
//  btn_play     in   1  raw play-mode button
//  trk_raw      in   3  raw tracker {L,C,R}, active-low, async
//  EN           out  1  debounced enable
//  House        out  1  mode outputs; at most one of House/Music/Speaker/Play high
//  Music        out  1
//  Speaker      out  1
//  Play         out  1
//  TL, TC, TR   out  1  filtered tracker, active-low, at most one low
// BEHAVIOUR
//  Reset (reset=0, async): EN=0, all modes=0, TL=TC=TR=1, FSM=IDLE, counters=0.
//   Button sync flops reset to 0; tracker sync flops reset to 1.
//  Sync: every raw input passes through 2 flops.
//  Debounce (per button incl. btn_en): counter counts edges where sync2 != db; any matching sample clears it.
//   db flips at the edge the count reaches DB_CYCLES.
//  Press: press = db & ~db_q (one cycle). Latency: raw sampled at edge k -> mode output changes at edge k+DB_CYCLES+2.
//  FSM states: IDLE, HOUSE, MUSIC, SPEAKER, PLAY, BLANK.
//   IDLE + press X (EN=1)    -> state X directly, no blank.
//   mode A + press B (B!=A)  -> BLANK for BLANK_CYCLES cycles (all modes 0), then B; target latched on entry.
//   mode A + press A         -> no change.
//   any + press off          -> IDLE.
//   BLANK + new press        -> target replaced, blank counter NOT restarted.
//   BLANK + off              -> IDLE.
//  Simultaneous presses, priority: off > Play > Speaker > Music > House.
//  EN: debounced btn_en, registered. EN=0 forces FSM to IDLE next edge and ignores all presses.
//   Re-enabling returns to IDLE, never to the previous mode.
//  Mode outputs are registered decodes of the state: one-hot in X, zero in IDLE/BLANK.
//  Tracker: sync2 pattern is valid if it has 0 or 1 zero bits. A stability counter increments while the pattern
//   equals the previous sample and is valid; it resets on change or invalid. TL/TC/TR load the pattern when the
//   count reaches TRK_STABLE. Invalid patterns (>=2 low) are never loaded; outputs hold.
//   Tracker filtering runs independently of EN and mode.
//  Counters saturate; no wrap-around.
// CONFIGURATION
//  THEATRE_CONSOLE_SHOWLOCK_EN defined: while in PLAY, House/Music/Speaker presses are ignored.
//   Only off or EN=0 leave PLAY.
//  Not defined: PLAY is left like any other mode.
// TESTING
//  T1 reset=0 mid-PLAY -> modes 0 and TL/TC/TR=111 immediately, without a clock edge.
//  T2 btn_en=1, btn_house pulse held 8 cycles -> House=1 exactly DB_CYCLES+2=6 edges after the sampling edge.
//  T3 btn_house toggling every 2 cycles (shorter than DB_CYCLES) -> House stays 0.
//  T4 In MUSIC, press btn_play -> 2 cycles all modes 0, then Play=1.
//   With SHOWLOCK_EN, a btn_house press then leaves Play=1.
//  T5 btn_play and btn_off pressed in the same cycle from SPEAKER -> IDLE, all modes 0.
//   btn_en=0 in PLAY -> Play=0 after debounce.
//  T6 trk_raw=011 held 3+ cycles -> TL=0 after sync+3 edges. trk_raw=001 held -> TL/TC/TR hold 011.
//   trk_raw=111 held -> outputs 111.

Source files
------------

// File: rtl/theatre_console.sv
// theatre_console
//   Front-of-house console conditioner for the lighting/video controller.
//   Raw operator buttons and stage-tracker sensors are synchronised and
//   filtered here. The block drives a debounced enable, a one-hot (or
//   all-zero) mode set, and filtered active-low tracker outputs. When the
//   operator moves from one active mode to another, an all-off blanking gap
//   is inserted so that the downstream lights never overlap.
//
//   Optional feature: define THEATRE_CONSOLE_SHOWLOCK_EN to lock PLAY. While
//   the console is in PLAY, House/Music/Speaker presses are ignored, and only
//   the off button or EN=0 can leave PLAY.
//
// Parameters
//   DB_CYCLES     consecutive differing samples needed before a button flips
//   BLANK_CYCLES  all-off cycles inserted between two active modes
//   TRK_STABLE    identical valid tracker samples needed before TL/TC/TR load
//
// Ports
//   clk                     in   system clock, rising edge
//   reset                   in   asynchronous, active-low reset
//   btn_en                  in   raw master-enable key switch
//   btn_off                 in   raw "all modes off" button
//   btn_house/music/
//     speaker/play          in   raw mode buttons
//   trk_raw[2:0]            in   raw tracker {L,C,R}, active-low
//   EN                      out  debounced enable
//   House/Music/Speaker/Play out registered mode outputs, at most one high
//   TL/TC/TR                out  filtered tracker, active-low, at most one low
module theatre_console #(
  parameter int DB_CYCLES    = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int TRK_STABLE   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_en,
  input  logic       btn_off,
  input  logic       btn_house,
  input  logic       btn_music,
  input  logic       btn_speaker,
  input  logic       btn_play,
  input  logic [2:0] trk_raw,
  output logic       EN,
  output logic       House,
  output logic       Music,
  output logic       Speaker,
  output logic       Play,
  output logic       TL,
  output logic       TC,
  output logic       TR
);

  localparam int NB  = 6;
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int BW  = $clog2(BLANK_CYCLES + 1);
  localparam int TW  = $clog2(TRK_STABLE + 1);

  // Bit positions in the button vectors
  localparam int I_HOUSE = 0;
  localparam int I_MUSIC = 1;
  localparam int I_SPK   = 2;
  localparam int I_PLAY  = 3;
  localparam int I_OFF   = 4;
  localparam int I_EN    = 5;

  typedef enum logic [2:0] {IDLE, HOUSE, MUSIC, SPEAKER, PLAY, BLANK} state_t;

  logic [NB-1:0]  btn_raw, btn_s1, btn_s2, db;
  logic [DBW-1:0] db_cnt [NB];
  logic [4:0]     db_q, press;
  state_t         state, state_next, target, target_next, sel;
  logic [BW-1:0]  blank_cnt, blank_cnt_next;
  logic [3:0]     mode_next;
  logic           lock;

  logic [2:0]     trk_s1, trk_s2, trk_prev;
  logic [TW-1:0]  trk_cnt, trk_cnt_inc;
  logic           trk_valid, trk_stable;

  assign btn_raw = {btn_en, btn_off, btn_play, btn_speaker, btn_music, btn_house};

  // Each button gets a two-flop synchroniser. The debounced level flips
  // only after DB_CYCLES consecutive samples that disagree with it. Any
  // agreeing sample clears the count, so a bounce shorter than that window
  // is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      db     <= '0;
      db_q   <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      db_q   <= db[4:0];
      for (int i = 0; i < NB; i++) begin
        if (btn_s2[i] != db[i]) begin
          if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
            db[i]     <= btn_s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db[4:0] & ~db_q;
  assign EN    = db[I_EN];

`ifdef THEATRE_CONSOLE_SHOWLOCK_EN
  assign lock = (state == PLAY);
`else
  assign lock = 1'b0;
`endif

  // The state register and the mode outputs are loaded on the same edge.
  // As a result, the outputs follow a press with no additional cycle of delay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      target    <= IDLE;
      blank_cnt <= '0;
      {House, Music, Speaker, Play} <= 4'b0000;
    end else begin
      state     <= state_next;
      target    <= target_next;
      blank_cnt <= blank_cnt_next;
      {House, Music, Speaker, Play} <= mode_next;
    end
  end

  // The next-state logic reuses IDLE as "no mode request" for sel. A press
  // that arrives during BLANK only retargets the gap. It does not stretch it.
  always_comb begin
    state_next     = state;
    target_next    = target;
    blank_cnt_next = blank_cnt;
    sel            = IDLE;
    if      (press[I_PLAY])  sel = PLAY;
    else if (press[I_SPK])   sel = SPEAKER;
    else if (press[I_MUSIC]) sel = MUSIC;
    else if (press[I_HOUSE]) sel = HOUSE;

    if (!EN || press[I_OFF]) begin
      state_next     = IDLE;
      blank_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel != IDLE) state_next = sel;
        end
        BLANK: begin
          if (sel != IDLE) target_next = sel;
          if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
            state_next     = target_next;
            blank_cnt_next = '0;
          end else begin
            blank_cnt_next = blank_cnt + 1'b1;
          end
        end
        default: begin
          if (sel != IDLE && sel != state && !lock) begin
            state_next     = BLANK;
            target_next    = sel;
            blank_cnt_next = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    mode_next = 4'b0000;
    case (state_next)
      HOUSE:   mode_next = 4'b1000;
      MUSIC:   mode_next = 4'b0100;
      SPEAKER: mode_next = 4'b0010;
      PLAY:    mode_next = 4'b0001;
      default: mode_next = 4'b0000;
    endcase
  end

  // A tracker pattern is valid when at most one sensor is low. A valid
  // pattern must repeat for TRK_STABLE samples before it is loaded. Invalid
  // patterns clear the count, so the outputs hold their last good value.
  always_comb begin
    case (trk_s2)
      3'b111, 3'b011, 3'b101, 3'b110: trk_valid = 1'b1;
      default:                        trk_valid = 1'b0;
    endcase
    trk_stable  = trk_valid && (trk_s2 == trk_prev);
    trk_cnt_inc = (trk_cnt == TW'(TRK_STABLE)) ? trk_cnt : trk_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trk_s1       <= 3'b111;
      trk_s2       <= 3'b111;
      trk_prev     <= 3'b111;
      trk_cnt      <= '0;
      {TL, TC, TR} <= 3'b111;
    end else begin
      trk_s1   <= trk_raw;
      trk_s2   <= trk_s1;
      trk_prev <= trk_s2;
      if (trk_stable) begin
        trk_cnt <= trk_cnt_inc;
        if (trk_cnt_inc == TW'(TRK_STABLE)) {TL, TC, TR} <= trk_s2;
      end else begin
        trk_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_theatre_console.sv
// tb_theatre_console
//   Scoreboard bench for theatre_console. The stimulus pushes each expected
//   output vector {EN,House,Music,Speaker,Play,TL,TC,TR}, together with the
//   edge number on which it must appear. A separate monitor pops one entry
//   every time the outputs change and compares both the value and the timing.
module tb_theatre_console;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_en = 1'b0;
  logic [4:0] btns = '0;          // {off, house, music, speaker, play}
  logic [2:0] trk_raw = 3'b111;
  logic       EN, House, Music, Speaker, Play, TL, TC, TR;
  logic [7:0] outs;

  typedef struct {
    logic [7:0] val;
    int         at;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         k;
  logic       mon_en = 1'b0;
  logic [7:0] last = '0;

  // Reference model state
  logic       en_m = 1'b0;
  logic [3:0] mode_m = 4'b0000;
  logic [2:0] trk_m = 3'b111;

  localparam logic [3:0] M_H = 4'b1000;
  localparam logic [3:0] M_M = 4'b0100;
  localparam logic [3:0] M_S = 4'b0010;
  localparam logic [3:0] M_P = 4'b0001;
  localparam int LAT = 6;         // raw sample edge -> mode output edge
  localparam int BLK = 2;         // blanking cycles

  theatre_console dut (
    .clk(clk), .reset(reset), .btn_en(btn_en),
    .btn_off(btns[4]), .btn_house(btns[3]), .btn_music(btns[2]),
    .btn_speaker(btns[1]), .btn_play(btns[0]), .trk_raw(trk_raw),
    .EN(EN), .House(House), .Music(Music), .Speaker(Speaker), .Play(Play),
    .TL(TL), .TC(TC), .TR(TR)
  );

  assign outs = {EN, House, Music, Speaker, Play, TL, TC, TR};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].at < cyc) begin
        total++;
        bad++;
        $display("[TB] FAIL missed_change: actual %b at cycle %0d, required %b at cycle %0d",
                 outs, cyc, sb[0].val, sb[0].at);
        sb.delete(0);
      end
      if (outs !== last) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_change: actual %b at cycle %0d, required %b", outs, cyc, last);
        end else begin
          e = sb[0];
          sb.delete(0);
          if (outs !== e.val || cyc != e.at) begin
            bad++;
            $display("[TB] FAIL change: actual %b at cycle %0d, required %b at cycle %0d",
                     outs, cyc, e.val, e.at);
          end
        end
      end
      last = outs;
    end
  end

  task automatic pushExp(input int at);
    exp_t x;
    x.val = {en_m, mode_m, trk_m};
    x.at  = at;
    sb.push_back(x);
  endtask

  task automatic modeDirect(input logic [3:0] m, input int at);
    mode_m = m;
    pushExp(at);
  endtask

  task automatic modeBlank(input logic [3:0] m, input int kk);
    mode_m = 4'b0000;
    pushExp(kk + LAT);
    mode_m = m;
    pushExp(kk + LAT + BLK);
  endtask

  task automatic applyStimulus(input logic [4:0] b, output int kk);
    @(negedge clk);
    btns = b;
    kk = cyc + 1;
  endtask

  task automatic holdRelease(input int hold);
    repeat (hold) @(negedge clk);
    btns = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic setTracker(input logic [2:0] p, input logic loads);
    @(negedge clk);
    trk_raw = p;
    if (loads) begin
      trk_m = p;
      pushExp(cyc + 1 + 5);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] req);
    total++;
    if (outs !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual %b required %b", name, outs, req);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 8'b0_0000_111);
    reset = 1'b1;
    @(negedge clk);
    last   = outs;
    mon_en = 1'b1;

    // Enable key on: EN follows 5 edges after the sampling edge
    @(negedge clk);
    btn_en = 1'b1;
    k = cyc + 1;
    en_m = 1'b1;
    pushExp(k + 5);
    repeat (12) @(negedge clk);

    // Bouncing house button, each level shorter than the debounce window
    for (int i = 0; i < 8; i++) begin
      btns[3] = ~btns[3];
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checkOutput("bounce_quiet", {en_m, mode_m, trk_m});

    // IDLE -> HOUSE directly
    applyStimulus(5'b01000, k); modeDirect(M_H, k + LAT); holdRelease(8);
    // HOUSE -> blank -> MUSIC
    applyStimulus(5'b00100, k); modeBlank(M_M, k); holdRelease(8);
    // Same mode again: nothing happens
    applyStimulus(5'b00100, k); holdRelease(8);
    checkOutput("same_mode", {en_m, mode_m, trk_m});
    // MUSIC -> blank -> PLAY
    applyStimulus(5'b00001, k); modeBlank(M_P, k); holdRelease(8);

    // Tracker filtering
    setTracker(3'b011, 1'b1);
    setTracker(3'b001, 1'b0);
    checkOutput("trk_invalid_hold", {en_m, mode_m, 3'b011});
    setTracker(3'b110, 1'b1);
    setTracker(3'b111, 1'b1);

    // House press while in PLAY
    applyStimulus(5'b01000, k);
`ifndef THEATRE_CONSOLE_SHOWLOCK_EN
    modeBlank(M_H, k);
`endif
    holdRelease(8);
    checkOutput("house_in_play", {en_m, mode_m, trk_m});

    // Off -> IDLE, then MUSIC directly
    applyStimulus(5'b10000, k); modeDirect(4'b0000, k + LAT); holdRelease(8);
    applyStimulus(5'b00100, k); modeDirect(M_M, k + LAT); holdRelease(8);

    // Retarget during blank: house then speaker one cycle later
    applyStimulus(5'b01000, k);
    modeBlank(M_S, k);
    @(negedge clk);
    btns = 5'b01010;
    holdRelease(7);

    // Play and off together from SPEAKER: off wins
    applyStimulus(5'b10001, k); modeDirect(4'b0000, k + LAT); holdRelease(8);
    // House and music together from IDLE: music wins
    applyStimulus(5'b01100, k); modeDirect(M_M, k + LAT); holdRelease(8);
    applyStimulus(5'b00001, k); modeBlank(M_P, k); holdRelease(8);

    // Enable off in PLAY
    @(negedge clk);
    btn_en = 1'b0;
    k = cyc + 1;
    en_m = 1'b0;
    pushExp(k + 5);
    mode_m = 4'b0000;
    pushExp(k + 6);
    repeat (12) @(negedge clk);
    applyStimulus(5'b00010, k); holdRelease(8);
    checkOutput("disabled_ignore", {en_m, mode_m, trk_m});

    // Re-enable returns to IDLE
    @(negedge clk);
    btn_en = 1'b1;
    k = cyc + 1;
    en_m = 1'b1;
    pushExp(k + 5);
    repeat (12) @(negedge clk);
    checkOutput("reenable_idle", {en_m, mode_m, trk_m});
    applyStimulus(5'b00001, k); modeDirect(M_P, k + LAT); holdRelease(8);
    setTracker(3'b101, 1'b1);
    checkOutput("pre_reset", 8'b1_0001_101);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
    end

    // Asynchronous reset mid-PLAY, checked before any clock edge
    mon_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 8'b0_0000_111);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
